// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath: ALU operation encodings,
// the hard-wired zero register, and the ALU-op legality check.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int ALUC_W = 3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd6,
    ALU_MIN = 3'd7
  } alu_op_e;

  // True for the operations the ALU actually implements.
  function automatic logic alu_op_legal(input logic [2:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_MIN: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// EX-stage operand forwarding for one source register. MEM beats WB,
// and $0 always reads as zero regardless of any writer targeting it.
module fwd_mux
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic [DATA_W-1:0] i_reg_val,
  input  logic              i_mem_reg_write,
  input  logic [REG_AW-1:0] i_mem_write_reg,
  input  logic [DATA_W-1:0] i_mem_result,
  input  logic              i_wb_reg_write,
  input  logic [REG_AW-1:0] i_wb_write_reg,
  input  logic [DATA_W-1:0] i_wb_result,
  output logic [DATA_W-1:0] o_value
);

  // Pick the youngest in-flight producer of i_src, else the captured value.
  always_comb begin
    // NOTE: default assignment first so every path drives o_value and no latch is inferred.
    o_value = i_reg_val;
    if (i_src == REG_AW'(REG_ZERO)) begin
      o_value = '0;
    end else if (i_mem_reg_write && (i_mem_write_reg == i_src)) begin
      o_value = i_mem_result;
    end else if (i_wb_reg_write && (i_wb_write_reg == i_src)) begin
      o_value = i_wb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand selection, MEM/WB forwarding,
// load-use bubble insertion, and external stall/flush control.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ALUC_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [15:0]       id_imm16,
  input  logic              id_zero_ext,
  input  logic              id_alu_src,
  input  logic [ALUC_W-1:0] id_alu_control,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_write_reg,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_result,
  output logic              load_use_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2_or_immediate,
  output logic [ALUC_W-1:0] ALU_control,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_write_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_illegal_op
);

  logic              r_valid;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm_ext;
  logic              r_alu_src;
  logic [ALUC_W-1:0] r_alu_control;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_write_reg;
  logic              r_reg_write;
  logic              r_mem_write;
  logic              r_mem_to_reg;
  logic              r_illegal;

  logic [DATA_W-1:0] w_imm_ext;
  logic [REG_AW-1:0] w_write_reg;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  // Capture-time decode: immediate extension and destination selection.
  assign w_imm_ext   = id_zero_ext ? {{(DATA_W-16){1'b0}}, id_imm16}
                                   : {{(DATA_W-16){id_imm16[15]}}, id_imm16};
  assign w_write_reg = id_reg_dst ? id_rd : id_rt;

  // A load in EX whose target is consumed by ID as a register operand
  // (rt counts when it feeds the ALU or is the store data).
  assign load_use_stall = ~stall & ~flush & id_valid & r_valid & r_mem_to_reg &
                          (r_write_reg != '0) &
                          ((r_write_reg == id_rs) |
                           ((r_write_reg == id_rt) & (~id_alu_src | id_mem_write)));

  // Pipeline register: flush > stall > load-use bubble > capture.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every flop is reset, and reset values equal the bubble values.
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all sequential state.
      r_valid       <= 1'b0;
      r_rd1         <= '0;
      r_rd2         <= '0;
      r_imm_ext     <= '0;
      r_alu_src     <= 1'b0;
      r_alu_control <= ALUC_W'(ALU_ADD);
      r_rs          <= '0;
      r_rt          <= '0;
      r_write_reg   <= '0;
      r_reg_write   <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_illegal     <= 1'b0;
    end else if (flush || load_use_stall) begin
      r_valid       <= 1'b0;
      r_rd1         <= '0;
      r_rd2         <= '0;
      r_imm_ext     <= '0;
      r_alu_src     <= 1'b0;
      r_alu_control <= ALUC_W'(ALU_ADD);
      r_rs          <= '0;
      r_rt          <= '0;
      r_write_reg   <= '0;
      r_reg_write   <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_illegal     <= 1'b0;
    end else if (!stall) begin
      r_valid       <= id_valid;
      r_rd1         <= id_rd1;
      r_rd2         <= id_rd2;
      r_imm_ext     <= w_imm_ext;
      r_alu_src     <= id_alu_src;
      r_alu_control <= id_alu_control;
      r_rs          <= id_rs;
      r_rt          <= id_rt;
      r_write_reg   <= w_write_reg;
      r_reg_write   <= id_reg_write & id_valid;
      r_mem_write   <= id_mem_write & id_valid;
      r_mem_to_reg  <= id_mem_to_reg & id_valid;
      r_illegal     <= id_valid & ~alu_op_legal(id_alu_control);
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .i_src           (r_rs),
    .i_reg_val       (r_rd1),
    .i_mem_reg_write (mem_reg_write),
    .i_mem_write_reg (mem_write_reg),
    .i_mem_result    (mem_alu_result),
    .i_wb_reg_write  (wb_reg_write),
    .i_wb_write_reg  (wb_write_reg),
    .i_wb_result     (wb_result),
    .o_value         (w_fwd_rs)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .i_src           (r_rt),
    .i_reg_val       (r_rd2),
    .i_mem_reg_write (mem_reg_write),
    .i_mem_write_reg (mem_write_reg),
    .i_mem_result    (mem_alu_result),
    .i_wb_reg_write  (wb_reg_write),
    .i_wb_write_reg  (wb_write_reg),
    .i_wb_result     (wb_result),
    .o_value         (w_fwd_rt)
  );

  assign ex_valid                 = r_valid;
  assign read_data_1              = w_fwd_rs;
  assign read_data_2_or_immediate = r_alu_src ? r_imm_ext : w_fwd_rt;
  assign ALU_control              = r_alu_control;
  assign ex_store_data            = w_fwd_rt;
  assign ex_write_reg             = r_write_reg;
  assign ex_reg_write             = r_reg_write;
  assign ex_mem_write             = r_mem_write;
  assign ex_mem_to_reg            = r_mem_to_reg;
  assign ex_illegal_op            = r_illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected EX-side
// responses computed by an instruction-level model; a monitor pops and compares.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, flush, id_valid;
  logic [31:0] id_rd1, id_rd2;
  logic [15:0] id_imm16;
  logic        id_zero_ext, id_alu_src;
  logic [2:0]  id_alu_control;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_reg_dst, id_reg_write, id_mem_write, id_mem_to_reg;
  logic        mem_reg_write;
  logic [4:0]  mem_write_reg;
  logic [31:0] mem_alu_result;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_result;
  logic        load_use_stall, ex_valid;
  logic [31:0] read_data_1, read_data_2_or_immediate, ex_store_data;
  logic [2:0]  ALU_control;
  logic [4:0]  ex_write_reg;
  logic        ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_illegal_op;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm16(id_imm16), .id_zero_ext(id_zero_ext),
    .id_alu_src(id_alu_src), .id_alu_control(id_alu_control), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
    .mem_alu_result(mem_alu_result), .wb_reg_write(wb_reg_write),
    .wb_write_reg(wb_write_reg), .wb_result(wb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .read_data_1(read_data_1),
    .read_data_2_or_immediate(read_data_2_or_immediate), .ALU_control(ALU_control),
    .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_illegal_op(ex_illegal_op)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        stall, flush, valid;
    logic [31:0] rd1, rd2;
    logic [15:0] imm;
    logic        zext, asrc;
    logic [2:0]  op;
    logic [4:0]  rs, rt, rd;
    logic        rdst, rw, mw, m2r;
    logic        mrw;
    logic [4:0]  mwr;
    logic [31:0] mres;
    logic        wrw;
    logic [4:0]  wwr;
    logic [31:0] wres;
  } stim_t;

  // The instruction currently sitting in EX, as the model sees it.
  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, wr;
    logic [31:0] a, b, imm;
    logic        asrc;
    logic [2:0]  op;
    logic        rw, mw, m2r;
  } ex_t;

  typedef struct {
    logic        lus, valid;
    logic [31:0] rd1, opb, store;
    logic [2:0]  op;
    logic [4:0]  wr;
    logic        rw, mw, m2r, ill;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  ex_t  m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic ex_t bubble();
    ex_t e;
    e = '{valid: 1'b0, rs: 5'd0, rt: 5'd0, wr: 5'd0, a: 32'd0, b: 32'd0, imm: 32'd0,
          asrc: 1'b0, op: 3'd2, rw: 1'b0, mw: 1'b0, m2r: 1'b0};
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t x;
    x = '{stall: 0, flush: 0, valid: 0, rd1: 0, rd2: 0, imm: 0, zext: 0, asrc: 0, op: 3'd2,
          rs: 0, rt: 0, rd: 0, rdst: 0, rw: 0, mw: 0, m2r: 0, mrw: 0, mwr: 0, mres: 0,
          wrw: 0, wwr: 0, wres: 0};
    return x;
  endfunction

  function automatic stim_t rand_stim();
    stim_t x;
    x.stall = ($urandom_range(0, 7) == 0);
    x.flush = ($urandom_range(0, 15) == 0);
    x.valid = ($urandom_range(0, 3) != 0);
    x.rd1   = $urandom;
    x.rd2   = $urandom;
    x.imm   = 16'($urandom);
    x.zext  = 1'($urandom);
    x.asrc  = 1'($urandom);
    x.op    = 3'($urandom_range(0, 7));
    x.rs    = 5'($urandom_range(0, 7));
    x.rt    = 5'($urandom_range(0, 7));
    x.rd    = 5'($urandom_range(0, 7));
    x.rdst  = 1'($urandom);
    x.rw    = 1'($urandom);
    x.mw    = 1'($urandom);
    x.m2r   = ($urandom_range(0, 2) == 0);
    x.mrw   = 1'($urandom);
    x.mwr   = 5'($urandom_range(0, 7));
    x.mres  = $urandom;
    x.wrw   = 1'($urandom);
    x.wwr   = 5'($urandom_range(0, 7));
    x.wres  = $urandom;
    return x;
  endfunction

  // Value an EX-stage reader of register s sees given the writers in flight.
  function automatic logic [31:0] fwd_ref(input logic [4:0] s, input logic [31:0] raw,
                                          input stim_t x);
    if (s == 5'd0) return 32'd0;
    if (x.mrw && x.mwr == s) return x.mres;
    if (x.wrw && x.wwr == s) return x.wres;
    return raw;
  endfunction

  function automatic logic is_legal(input logic [2:0] op);
    return op inside {3'd0, 3'd1, 3'd2, 3'd6, 3'd7};
  endfunction

  function automatic logic lus_ref(input ex_t e, input stim_t x);
    if (x.stall || x.flush || !x.valid || !e.valid || !e.m2r || e.wr == 5'd0) return 1'b0;
    return (e.wr == x.rs) || (e.wr == x.rt && (!x.asrc || x.mw));
  endfunction

  function automatic ex_t next_ex(input ex_t e, input stim_t x);
    ex_t n;
    if (x.flush) return bubble();
    if (x.stall) return e;
    if (lus_ref(e, x)) return bubble();
    n.valid = x.valid;
    n.rs    = x.rs;
    n.rt    = x.rt;
    n.wr    = x.rdst ? x.rd : x.rt;
    n.a     = x.rd1;
    n.b     = x.rd2;
    n.imm   = x.zext ? {16'h0000, x.imm} : 32'($signed(x.imm));
    n.asrc  = x.asrc;
    n.op    = x.op;
    n.rw    = x.rw & x.valid;
    n.mw    = x.mw & x.valid;
    n.m2r   = x.m2r & x.valid;
    return n;
  endfunction

  task automatic apply(input stim_t x);
    stall = x.stall; flush = x.flush; id_valid = x.valid;
    id_rd1 = x.rd1; id_rd2 = x.rd2; id_imm16 = x.imm; id_zero_ext = x.zext;
    id_alu_src = x.asrc; id_alu_control = x.op;
    id_rs = x.rs; id_rt = x.rt; id_rd = x.rd; id_reg_dst = x.rdst;
    id_reg_write = x.rw; id_mem_write = x.mw; id_mem_to_reg = x.m2r;
    mem_reg_write = x.mrw; mem_write_reg = x.mwr; mem_alu_result = x.mres;
    wb_reg_write = x.wrw; wb_write_reg = x.wwr; wb_result = x.wres;
  endtask

  // One cycle: drive at the falling edge, predict this cycle's outputs, advance the model.
  task automatic drive(input stim_t x);
    exp_t e;
    @(negedge clk);
    apply(x);
    e.lus   = lus_ref(m, x);
    e.valid = m.valid;
    e.rd1   = fwd_ref(m.rs, m.a, x);
    e.store = fwd_ref(m.rt, m.b, x);
    e.opb   = m.asrc ? m.imm : e.store;
    e.op    = m.op;
    e.wr    = m.wr;
    e.rw    = m.rw;
    e.mw    = m.mw;
    e.m2r   = m.m2r;
    e.ill   = m.valid && !is_legal(m.op);
    sb.push_back(e);
    m = next_ex(m, x);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(ex_valid), 32'd0);
    check({tag, "_aluc"}, 32'(ALU_control), 32'd2);
    check({tag, "_ctl"}, {29'd0, ex_reg_write, ex_mem_write, ex_mem_to_reg}, 32'd0);
    check({tag, "_ill"}, 32'(ex_illegal_op), 32'd0);
  endtask

  // Monitor: compare every predicted cycle away from the clock edges.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("load_use_stall", 32'(load_use_stall), 32'(e.lus));
        check("ex_valid", 32'(ex_valid), 32'(e.valid));
        check("read_data_1", read_data_1, e.rd1);
        check("operand_b", read_data_2_or_immediate, e.opb);
        check("store_data", ex_store_data, e.store);
        check("ALU_control", 32'(ALU_control), 32'(e.op));
        check("write_reg", 32'(ex_write_reg), 32'(e.wr));
        check("ctl", {29'd0, ex_reg_write, ex_mem_write, ex_mem_to_reg},
              {29'd0, e.rw, e.mw, e.m2r});
        check("illegal_op", 32'(ex_illegal_op), 32'(e.ill));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t x, y;
    apply(idle());
    m = bubble();
    repeat (2) @(negedge clk);
    check_reset_values("reset_init");
    rst_n = 1'b1;
    m = next_ex(m, idle());

    // addi with sign- and zero-extended immediate
    x = idle(); x.valid = 1; x.rs = 5'd1; x.rd1 = 32'd5; x.rt = 5'd2; x.imm = 16'hFFFF;
    x.asrc = 1; x.rw = 1;
    drive(x); drive(idle()); #3;
    check("addi_rs", read_data_1, 32'd5);
    check("addi_sext", read_data_2_or_immediate, 32'hFFFF_FFFF);
    x.zext = 1;
    drive(x); drive(idle()); #3;
    check("addi_zext", read_data_2_or_immediate, 32'h0000_FFFF);

    // forwarding priority MEM > WB, and $0 never forwarded
    x = idle(); x.valid = 1; x.rs = 5'd3; x.rd1 = 32'h11;
    drive(x);
    y = idle(); y.stall = 1; y.mrw = 1; y.mwr = 5'd3; y.mres = 32'hAA;
    y.wrw = 1; y.wwr = 5'd3; y.wres = 32'hBB;
    drive(y); #3;
    check("fwd_mem", read_data_1, 32'hAA);
    y.mrw = 0;
    drive(y); #3;
    check("fwd_wb", read_data_1, 32'hBB);
    x.rs = 5'd0; x.rd1 = 32'h77;
    drive(x);
    y.stall = 0; y.mrw = 1; y.mwr = 5'd0; y.wwr = 5'd0;
    drive(y); #3;
    check("fwd_zero", read_data_1, 32'd0);

    // load-use: lw $4 then add using $4
    x = idle(); x.valid = 1; x.rs = 5'd1; x.rt = 5'd4; x.asrc = 1; x.rw = 1; x.m2r = 1;
    drive(x);
    y = idle(); y.valid = 1; y.rs = 5'd4; y.rt = 5'd5; y.rd = 5'd6; y.rdst = 1; y.rw = 1;
    y.rd1 = 32'hDEAD;
    drive(y); #3;
    check("lus_raised", 32'(load_use_stall), 32'd1);
    y.mrw = 1; y.mwr = 5'd4; y.mres = 32'h1234;
    drive(y); #3;
    check("lus_bubble", 32'(ex_valid), 32'd0);
    x = idle(); x.mrw = 1; x.mwr = 5'd4; x.mres = 32'h1234;
    drive(x); #3;
    check("lus_issue_valid", 32'(ex_valid), 32'd1);
    check("lus_issue_fwd", read_data_1, 32'h1234);

    // stall holds for three cycles, then flush+stall bubbles
    x = rand_stim(); x.stall = 0; x.flush = 0; x.valid = 1; x.mrw = 0; x.wrw = 0;
    drive(x);
    for (int i = 0; i < 3; i++) begin
      y = rand_stim(); y.stall = 1; y.flush = 0; y.mrw = 0; y.wrw = 0;
      drive(y);
    end
    y = rand_stim(); y.stall = 1; y.flush = 1; y.valid = 1;
    drive(y); drive(idle()); #3;
    check("flush_over_stall", 32'(ex_valid), 32'd0);

    // illegal op captured, then cleared by a bubble
    x = idle(); x.valid = 1; x.op = 3'd3;
    drive(x);
    y = idle(); y.flush = 1;
    drive(y); #3;
    check("illegal_set", 32'(ex_illegal_op), 32'd1);
    drive(idle()); #3;
    check("illegal_cleared", 32'(ex_illegal_op), 32'd0);

    for (int i = 0; i < 300; i++) drive(rand_stim());

    // asynchronous reset in the middle of a cycle, while a stall is held
    x = rand_stim(); x.stall = 0; x.flush = 0; x.valid = 1; x.m2r = 1; x.rw = 1;
    drive(x);
    y = rand_stim(); y.stall = 1; y.flush = 0;
    drive(y);
    @(posedge clk); #3;
    rst_n = 1'b0;
    apply(idle());
    #1;
    check_reset_values("reset_async");
    m = bubble();
    @(negedge clk);
    rst_n = 1'b1;
    m = next_ex(m, idle());

    for (int i = 0; i < 200; i++) drive(rand_stim());

    repeat (2) @(negedge clk);
    #3;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
